// File: rtl/seq_detect_ctrl_if.sv
// Configuration handshake bundle for seq_detect_ctrl.
// Carries cfg_timeout only when SEQ_DET_TIMEOUT_EN is defined.
interface seq_detect_ctrl_if #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
`ifdef SEQ_DET_TIMEOUT_EN
    , parameter int TO_W = 8
`endif
);
    localparam int LEN_W = $clog2(PAT_W) + 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
`ifdef SEQ_DET_TIMEOUT_EN
    logic [TO_W-1:0]  cfg_timeout;
`endif

    modport master (
        input  cfg_ready,
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target
`ifdef SEQ_DET_TIMEOUT_EN
        , cfg_timeout
`endif
    );

    modport slave (
        output cfg_ready,
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target
`ifdef SEQ_DET_TIMEOUT_EN
        , cfg_timeout
`endif
    );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Run-time configurable serial sequence detector with match counter and target.
// Optional inactivity timeout is enabled by defining SEQ_DET_TIMEOUT_EN.
module seq_detect_ctrl #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 8
`ifdef SEQ_DET_TIMEOUT_EN
    , parameter int TO_W = 8
`endif
) (
    input  logic             clk,
    input  logic             clear_n,
    seq_detect_ctrl_if.slave cfg,
    input  logic             start,
    input  logic             stop,
    input  logic             x,
    input  logic             x_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             busy,
    output logic             done
`ifdef SEQ_DET_TIMEOUT_EN
    , output logic           timeout
`endif
);
    localparam int LEN_W = $clog2(PAT_W) + 1;
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             configured_r;
    logic [PAT_W-1:0] pat_r;
    logic [LEN_W-1:0] len_r;
    logic             ovl_r;
    logic [CNT_W-1:0] tgt_r;
    logic [PAT_W-1:0] hist_r;
    logic [LEN_W-1:0] fill_r;
    logic [CNT_W-1:0] count_r;
    logic             match_r, busy_r, done_r, ready_r;

    logic             do_cfg_s, do_start_s, sample_s, hit_s, tgt_hit_s, to_hit_s;
    logic [PAT_W-1:0] new_hist_s;
    logic [LEN_W-1:0] fill_inc_s, len_in_s;
    logic [CNT_W-1:0] cnt_inc_s;

    function automatic logic [PAT_W-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [PAT_W-1:0] m;
        m = '0;
        for (int i = 0; i < PAT_W; i++) begin
            m[i] = (i < int'(len));
        end
        return m;
    endfunction

    assign new_hist_s = {hist_r[PAT_W-2:0], x};
    assign fill_inc_s = fill_r + LEN_W'(1);
    assign cnt_inc_s  = (count_r == CNT_MAX) ? count_r : count_r + CNT_W'(1);
    assign len_in_s   = ((cfg.cfg_len == '0) || (cfg.cfg_len > LEN_MAX)) ? LEN_MAX : cfg.cfg_len;
    // stop outranks a simultaneous match, so it gates sampling entirely
    assign sample_s   = (state_r == ST_RUN) && x_valid && !stop;
    assign hit_s      = sample_s && (fill_inc_s >= len_r)
                        && (((new_hist_s ^ pat_r) & len_mask(len_r)) == '0);
    assign tgt_hit_s  = (tgt_r != '0) && (cnt_inc_s == tgt_r);

`ifdef SEQ_DET_TIMEOUT_EN
    logic [TO_W-1:0] to_r, to_cnt_r;
    logic            timeout_r;
    assign to_hit_s = sample_s && !hit_s && (to_r != '0) && ((to_cnt_r + TO_W'(1)) == to_r);
    assign timeout  = timeout_r;
`else
    assign to_hit_s = 1'b0;
`endif

    // Next-state and control strobes
    always_comb begin
        state_nxt_s = state_r;
        do_cfg_s    = 1'b0;
        do_start_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cfg.cfg_valid) begin
                    do_cfg_s = 1'b1;
                end else if (start && configured_r) begin
                    do_start_s  = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if ((hit_s && tgt_hit_s) || to_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else if (start) begin
                    do_start_s  = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, configuration, history and counter registers
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r      <= ST_IDLE;
            configured_r <= 1'b0;
            pat_r        <= '0;
            len_r        <= LEN_MAX;
            ovl_r        <= 1'b0;
            tgt_r        <= '0;
            hist_r       <= '0;
            fill_r       <= '0;
            count_r      <= '0;
            match_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ready_r      <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ready_r <= (state_nxt_s == ST_IDLE);
            busy_r  <= (state_nxt_s == ST_RUN);
            done_r  <= (state_nxt_s == ST_DONE);
            match_r <= hit_s;
            if (do_cfg_s) begin
                configured_r <= 1'b1;
                pat_r        <= cfg.cfg_pattern;
                len_r        <= len_in_s;
                ovl_r        <= cfg.cfg_overlap;
                tgt_r        <= cfg.cfg_target;
            end
            if (do_start_s) begin
                count_r <= '0;
                hist_r  <= '0;
                fill_r  <= '0;
            end else if (sample_s) begin
                if (hit_s) begin
                    count_r <= cnt_inc_s;
                end
                if (hit_s && !ovl_r) begin
                    hist_r <= '0;
                    fill_r <= '0;
                end else begin
                    hist_r <= new_hist_s;
                    fill_r <= (fill_r == LEN_MAX) ? fill_r : fill_inc_s;
                end
            end
        end
    end

`ifdef SEQ_DET_TIMEOUT_EN
    // Inactivity counter: reloads on every match, fires DONE when it reaches the limit
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            to_r      <= '0;
            to_cnt_r  <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (do_cfg_s) begin
                to_r <= cfg.cfg_timeout;
            end
            if (do_start_s) begin
                to_cnt_r <= '0;
            end else if (sample_s) begin
                to_cnt_r <= hit_s ? '0 : to_cnt_r + TO_W'(1);
            end
            if (do_start_s || stop) begin
                timeout_r <= 1'b0;
            end else if (to_hit_s) begin
                timeout_r <= 1'b1;
            end
        end
    end
`endif

    assign cfg.cfg_ready = ready_r;
    assign match         = match_r;
    assign match_count   = count_r;
    assign busy          = busy_r;
    assign done          = done_r;
endmodule
